mac_dot_seq: RTL



---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_dot_seq_if.sv | 36 +++
 rtl/mac_dot_seq_buf.sv | 33 +++
 rtl/mac_dot_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC stage and its wrappers: sequencer states and
// accumulator width helper.
package mac_pkg;

    typedef enum logic [2:0] {
        LOAD,
        CLR,
        RUN,
        WAIT,
        DONE
    } seq_state_e;

    function automatic int unsigned acc_width(input int unsigned data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Operand-in, MAC-drive and result-out signals of mac_dot_seq. The master
// modport is the sequencer side; slave is the source/MAC/consumer side.
interface mac_dot_seq_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) ();

    localparam int unsigned ACC_W = acc_width(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;

    logic                  mac_en;
    logic                  mac_clr;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [ACC_W-1:0]      mac_cout;

    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_W-1:0]      res_data;

    modport master (
        input  in_valid, in_a, in_b, mac_cout, res_ready,
        output in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
    );

    modport slave (
        output in_valid, in_a, in_b, mac_cout, res_ready,
        input  in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
    );

endinterface

// File: rtl/mac_dot_seq_buf.sv
// Two-lane operand register file: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module mac_dot_seq_buf
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_a,
    input  logic [DATA_WIDTH-1:0] wr_b,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_a,
    output logic [DATA_WIDTH-1:0] rd_b
);

    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/mac_dot_seq.sv
// Operand sequencer for the MAC: buffers VEC_LEN pairs, runs one clean dot
// product (Clr then En), captures Cout. Optional dot_cnt: MAC_DOT_SEQ_CNT_EN.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LEN    = 8
) (
    input  logic                clk,
    input  logic                rst,
    mac_dot_seq_if.master       bus
`ifdef MAC_DOT_SEQ_CNT_EN
    ,
    output logic [15:0]         dot_cnt
`endif
);

    localparam int unsigned CW    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned ACC_W = acc_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    seq_state_e state, state_nxt;

    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [ACC_W-1:0]      res_data_q;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    logic in_ready;
    logic wr_en;
    logic mac_en;
    logic mac_clr;
    logic res_valid;

    mac_dot_seq_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (VEC_LEN),
        .AW         (CW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_a    (bus.in_a),
        .wr_b    (bus.in_b),
        .rd_addr (rd_cnt),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        res_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST) begin
                        state_nxt = CLR;
                    end
                end
            end
            CLR: begin
                mac_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                mac_en = 1'b1;
                if (rd_cnt == LAST) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Counters wrap explicitly so non-power-of-two VEC_LEN stays in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            res_data_q <= '0;
        end else begin
            if (wr_en) begin
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
            end
            if (state == CLR) begin
                rd_cnt <= '0;
            end else if (mac_en) begin
                rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
            end
            if (state == WAIT) begin
                res_data_q <= bus.mac_cout;
            end
        end
    end

`ifdef MAC_DOT_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_cnt <= '0;
        end else if (res_valid && bus.res_ready) begin
            dot_cnt <= dot_cnt + 16'd1;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.mac_en    = mac_en;
    assign bus.mac_clr   = mac_clr;
    assign bus.mac_a     = mac_en ? rd_a : '0;
    assign bus.mac_b     = mac_en ? rd_b : '0;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data_q;

endmodule
